// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port, byte-writable 32-bit RAM between
// m0 (CPU load/store) and m1 (display engine).
//   clk, rst              clock, synchronous active-high reset
//   m0_* / m1_*           master request (req/we/addr/wdata), grant, read return
//   ram_cs/we/addr/din    RAM command for the granted master
//   ram_dout              RAM read data, one cycle after ram_cs
// m1 wins contention until it has been granted MAX_STREAK times in a row while
// m0 waited; then m0 gets one slot.
module ram_port_arbiter #(
    parameter int unsigned AW         = 12,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          ram_cs,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] STREAK_LIMIT = SW'(MAX_STREAK);

    logic [SW-1:0] streak;
    logic          rd_pend;
    logic          rd_owner;   // 0 = m0, 1 = m1

    // Grant decision: m1 priority unless m0 has waited through a full streak.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m1_req && (!m0_req || (streak != STREAK_LIMIT))) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end
        end
    end

    // RAM command mux; all zero when nobody is granted.
    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 4'b0000;
        ram_addr = '0;
        ram_din  = 32'd0;
        if (m1_gnt) begin
            ram_cs   = 1'b1;
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end else if (m0_gnt) begin
            ram_cs   = 1'b1;
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end
    end

    // Streak counter and read-return owner tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak   <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (m1_gnt && m0_req) begin
                streak <= (streak == STREAK_LIMIT) ? streak : streak + SW'(1);
            end else begin
                streak <= '0;
            end
            rd_pend <= ram_cs && (ram_we == 4'b0000);
            if (ram_cs && (ram_we == 4'b0000)) begin
                rd_owner <= m1_gnt;
            end
        end
    end

    // Return steering; rst masks a return already in flight.
    always_comb begin
        m0_rvalid = rd_pend && !rst && !rd_owner;
        m1_rvalid = rd_pend && !rst && rd_owner;
        m0_rdata  = m0_rvalid ? ram_dout : 32'd0;
        m1_rdata  = m1_rvalid ? ram_dout : 32'd0;
    end

endmodule
